// File: rtl/touch_debounce_pkg.sv
// Shared definitions for the touch-pad conditioning path: FSM encoding,
// 50 MHz default timings and a counter-width helper.
package touch_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } touch_state_t;

    // 20 ms debounce and 1 s long-press at 50 MHz
    localparam int DEF_DEB_CYCLES  = 1_000_000;
    localparam int DEF_LONG_CYCLES = 50_000_000;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/touch_debounce_sync_2ff.sv
// Two-flop synchroniser for one asynchronous pad level; reset loads RST_VAL
// so a reset never looks like a pad transition.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d,
    output logic q
);

    logic sync1;
    logic sync2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/touch_debounce.sv
// Touch-pad conditioner: synchronise, debounce, and emit registered
// press / release / long-press pulses plus a clean level.
module touch_debounce
    import touch_debounce_pkg::*;
#(
    parameter logic TOUCH_ACTIVE = 1'b0,
    parameter int   DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int   LONG_CYCLES  = DEF_LONG_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       touch_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [1:0] dbg_state
);

    localparam int DEB_W  = cnt_width(DEB_CYCLES);
    localparam int LONG_W = cnt_width(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    if (DEB_CYCLES < 2) begin : g_deb_guard
        $error("touch_debounce: DEB_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEB_CYCLES) begin : g_long_guard
        $error("touch_debounce: LONG_CYCLES must be > DEB_CYCLES");
    end

    touch_state_t      state;
    touch_state_t      state_next;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DEB_W-1:0]  deb_cnt_next;
    logic [LONG_W-1:0] long_cnt;
    logic [LONG_W-1:0] long_cnt_next;
    logic              long_done;
    logic              long_done_next;
    logic              level_next;
    logic              press_next;
    logic              release_next;
    logic              long_next;
    logic              pad_sync;
    logic              s2;

    sync_2ff #(
        .RST_VAL (~TOUCH_ACTIVE)
    ) u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (touch_in),
        .q       (pad_sync)
    );

    assign s2        = (pad_sync == TOUCH_ACTIVE);
    assign dbg_state = state;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_next;
            deb_cnt     <= deb_cnt_next;
            long_cnt    <= long_cnt_next;
            long_done   <= long_done_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (s2) state_next = ST_PRESS_DB;
            end
            ST_PRESS_DB: begin
                if (!s2)                   state_next = ST_IDLE;
                else if (deb_cnt == DEB_LAST) state_next = ST_HELD;
            end
            ST_HELD: begin
                if (!s2) state_next = ST_RELEASE_DB;
            end
            ST_RELEASE_DB: begin
                if (s2)                    state_next = ST_HELD;
                else if (deb_cnt == DEB_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A bounce back to touched during release debounce keeps long_cnt frozen,
    // so the long-press deadline slips by the time spent out of HELD.
    always_comb begin
        deb_cnt_next   = deb_cnt;
        long_cnt_next  = long_cnt;
        long_done_next = long_done;
        level_next     = key_level;
        press_next     = 1'b0;
        release_next   = 1'b0;
        long_next      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s2) deb_cnt_next = '0;
            end
            ST_PRESS_DB: begin
                if (!s2) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    press_next = 1'b1;
                    level_next = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + DEB_W'(1);
                end
            end
            ST_HELD: begin
                if (!s2) begin
                    deb_cnt_next = '0;
                end else begin
                    if (long_cnt == LONG_LAST && !long_done) begin
                        long_next      = 1'b1;
                        long_done_next = 1'b1;
                    end
                    if (long_cnt != LONG_LAST) long_cnt_next = long_cnt + LONG_W'(1);
                end
            end
            ST_RELEASE_DB: begin
                if (!s2) begin
                    if (deb_cnt == DEB_LAST) begin
                        release_next   = 1'b1;
                        level_next     = 1'b0;
                        long_cnt_next  = '0;
                        long_done_next = 1'b0;
                    end else begin
                        deb_cnt_next = deb_cnt + DEB_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
